// File: rtl/fp_session_ctrl.sv
// Fingerprint session controller: sequences enroll / capture+match operations,
// drives the packet-engine and match-engine handshakes, and owns the status LEDs.
module fp_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 33_000_000,
  parameter int CNT_W          = 26,
  parameter int RIGHT_TH       = 50,
  parameter int FALSE_TH       = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update_req,
  input  logic       check_req,
  output logic       pkt_start,
  output logic [1:0] pkt_cmd,
  input  logic       pkt_done,
  input  logic       pkt_err,
  output logic       write_sel,
  output logic       match_start,
  input  logic       match_done,
  input  logic [7:0] max_right,
  input  logic [7:0] max_false,
  output logic       busy,
  output logic       update_led,
  output logic       check_done,
  output logic       match_ok,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENR_ISSUE,
    S_ENR_WAIT,
    S_CHK_ISSUE,
    S_CHK_WAIT,
    S_MATCH_ISSUE,
    S_MATCH_WAIT,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       LP_RIGHT_TH = 8'(RIGHT_TH);
  localparam logic [7:0]       LP_FALSE_TH = 8'(FALSE_TH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pkt_start;
  logic [1:0]       r_pkt_cmd;
  logic             r_write_sel;
  logic             r_match_start;
  logic             r_busy;
  logic             r_update_led;
  logic             r_check_done;
  logic             r_match_ok;
  logic             r_err;

  logic w_timeout;
  logic w_pass;

  assign w_timeout = (r_cnt == LP_LAST);
  assign w_pass    = (max_right > LP_RIGHT_TH) && (max_false < LP_FALSE_TH);

  // Every output is registered on the edge that enters the state it belongs to,
  // so strobes and flags are visible during that state's own cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pkt_start   <= 1'b0;
      r_pkt_cmd     <= 2'b00;
      r_write_sel   <= 1'b0;
      r_match_start <= 1'b0;
      r_busy        <= 1'b0;
      r_update_led  <= 1'b0;
      r_check_done  <= 1'b0;
      r_match_ok    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_pkt_start   <= 1'b0;
      r_pkt_cmd     <= 2'b00;
      r_match_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (update_req) begin
            r_state      <= S_ENR_ISSUE;
            r_pkt_start  <= 1'b1;
            r_pkt_cmd    <= 2'b01;
            r_write_sel  <= 1'b0;
            r_busy       <= 1'b1;
            r_err        <= 1'b0;
            r_check_done <= 1'b0;
            r_match_ok   <= 1'b0;
          end else if (check_req) begin
            if (r_update_led) begin
              r_state      <= S_CHK_ISSUE;
              r_pkt_start  <= 1'b1;
              r_pkt_cmd    <= 2'b10;
              r_write_sel  <= 1'b1;
              r_busy       <= 1'b1;
              r_err        <= 1'b0;
              r_check_done <= 1'b0;
              r_match_ok   <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ENR_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_ENR_WAIT;
        end
        S_ENR_WAIT: begin
          if (pkt_done) begin
            r_update_led <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (pkt_err || w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CHK_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_CHK_WAIT;
        end
        S_CHK_WAIT: begin
          if (pkt_done) begin
            r_match_start <= 1'b1;
            r_state       <= S_MATCH_ISSUE;
          end else if (pkt_err || w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_MATCH_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_MATCH_WAIT;
        end
        S_MATCH_WAIT: begin
          if (match_done) begin
            r_match_ok   <= w_pass;
            r_check_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pkt_start   = r_pkt_start;
  assign pkt_cmd     = r_pkt_cmd;
  assign write_sel   = r_write_sel;
  assign match_start = r_match_start;
  assign busy        = r_busy;
  assign update_led  = r_update_led;
  assign check_done  = r_check_done;
  assign match_ok    = r_match_ok;
  assign err         = r_err;

endmodule

// File: tb/tb_fp_session_ctrl.sv
// Bench for fp_session_ctrl: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a session-level reference model.
module tb_fp_session_ctrl;

  localparam int TMO   = 16;
  localparam int R_TH  = 50;
  localparam int F_TH  = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update_req = 1'b0;
  logic       check_req  = 1'b0;
  logic       pkt_done   = 1'b0;
  logic       pkt_err    = 1'b0;
  logic       match_done = 1'b0;
  logic [7:0] max_right  = '0;
  logic [7:0] max_false  = '0;
  logic       pkt_start;
  logic [1:0] pkt_cmd;
  logic       write_sel;
  logic       match_start;
  logic       busy;
  logic       update_led;
  logic       check_done;
  logic       match_ok;
  logic       err;

  fp_session_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(8),
    .RIGHT_TH(R_TH),
    .FALSE_TH(F_TH)
  ) dut (
    .clk(clk), .rst(rst),
    .update_req(update_req), .check_req(check_req),
    .pkt_start(pkt_start), .pkt_cmd(pkt_cmd), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .write_sel(write_sel), .match_start(match_start), .match_done(match_done),
    .max_right(max_right), .max_false(max_false),
    .busy(busy), .update_led(update_led), .check_done(check_done),
    .match_ok(match_ok), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: what a session is doing, described by the kind of session,
  // what it is awaiting, and how many wait cycles of budget remain.
  bit       m_ps, m_ms, m_ws, m_busy, m_led, m_cd, m_ok, m_err;
  bit [1:0] m_cmd;
  int       m_kind;     // 0 none, 1 enroll, 2 check
  int       m_await;    // 0 nothing, 1 packet engine, 2 match engine
  int       m_budget;
  bit       m_err_cycle;

  task automatic model_reset();
    m_ps = 0; m_ms = 0; m_ws = 0; m_busy = 0; m_led = 0; m_cd = 0; m_ok = 0; m_err = 0;
    m_cmd = 2'b00; m_kind = 0; m_await = 0; m_budget = 0; m_err_cycle = 0;
  endtask

  task automatic model_begin(input int kind);
    m_kind = kind;
    m_ps   = 1;
    m_cmd  = (kind == 1) ? 2'b01 : 2'b10;
    m_ws   = (kind == 2);
    m_busy = 1; m_err = 0; m_cd = 0; m_ok = 0;
  endtask

  task automatic model_edge(input bit ur, input bit cr, input bit pd, input bit pe,
                            input bit md, input int mr, input int mf);
    bit was_pkt, was_match;
    was_pkt = m_ps; was_match = m_ms;
    m_ps = 0; m_ms = 0; m_cmd = 2'b00;
    if (!m_busy) begin
      if (ur) model_begin(1);
      else if (cr) begin
        if (m_led) model_begin(2);
        else m_err = 1;
      end
    end else if (m_err_cycle) begin
      m_err_cycle = 0; m_busy = 0; m_kind = 0;
    end else if (was_pkt || was_match) begin
      m_await  = was_pkt ? 1 : 2;
      m_budget = TMO;
    end else begin
      m_budget = m_budget - 1;
      if (m_await == 1 && pd) begin
        m_await = 0;
        if (m_kind == 1) begin m_led = 1; m_busy = 0; m_kind = 0; end
        else m_ms = 1;
      end else if (m_await == 2 && md) begin
        m_await = 0; m_cd = 1; m_ok = (mr > R_TH) && (mf < F_TH);
        m_busy = 0; m_kind = 0;
      end else if ((m_await == 1 && pe) || m_budget == 0) begin
        m_await = 0; m_err = 1; m_err_cycle = 1;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_edge(update_req, check_req, pkt_done, pkt_err, match_done,
                    int'(max_right), int'(max_false));
  end

  int n_checks = 0;
  int n_pass   = 0;
  int ps_cnt   = 0;
  int ms_cnt   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("pkt_start",   int'(pkt_start),   int'(m_ps));
    chk("pkt_cmd",     int'(pkt_cmd),     int'(m_cmd));
    chk("write_sel",   int'(write_sel),   int'(m_ws));
    chk("match_start", int'(match_start), int'(m_ms));
    chk("busy",        int'(busy),        int'(m_busy));
    chk("update_led",  int'(update_led),  int'(m_led));
    chk("check_done",  int'(check_done),  int'(m_cd));
    chk("match_ok",    int'(match_ok),    int'(m_ok));
    chk("err",         int'(err),         int'(m_err));
    if (pkt_start === 1'b1) ps_cnt++;
    if (match_start === 1'b1) ms_cnt++;
  endtask

  task automatic step(input bit ur, input bit cr, input bit pd, input bit pe,
                      input bit md, input int mr, input int mf);
    update_req = ur; check_req = cr; pkt_done = pd; pkt_err = pe; match_done = md;
    max_right = 8'(mr); max_false = 8'(mf);
    @(posedge clk); #1;
    update_req = 0; check_req = 0; pkt_done = 0; pkt_err = 0; match_done = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_check(input string name, input int mr, input int mf, input int exp_ok);
    int bps, bms;
    bps = ps_cnt; bms = ms_cnt;
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, mr, mf);
    chk({name, "_check_done"}, int'(check_done), 1);
    chk({name, "_match_ok"},   int'(match_ok),   exp_ok);
    chk({name, "_busy"},       int'(busy),       0);
    chk({name, "_write_sel"},  int'(write_sel),  1);
    chk({name, "_n_match"},    ms_cnt - bms,     1);
    chk({name, "_n_pkt"},      ps_cnt - bps,     1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bps, bms;
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_led",  int'(update_led), 0);
    chk("rst_cmd",  int'(pkt_cmd), 0);
    chk("rst_err",  int'(err), 0);

    // check before any enroll: error, no command
    bps = ps_cnt;
    step(0, 1, 0, 0, 0, 0, 0);
    chk("early_chk_err", int'(err), 1);
    idle(3);
    chk("early_chk_npkt", ps_cnt - bps, 0);
    chk("early_chk_busy", int'(busy), 0);

    // enroll with done 5 cycles after request
    bps = ps_cnt;
    step(1, 0, 0, 0, 0, 0, 0);
    chk("enr_cmd", int'(pkt_cmd), 1);
    chk("enr_ws",  int'(write_sel), 0);
    chk("enr_err_clr", int'(err), 0);
    idle(4);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("enr_led",  int'(update_led), 1);
    chk("enr_busy", int'(busy), 0);
    chk("enr_npkt", ps_cnt - bps, 1);

    run_check("pass",   51,  79, 1);
    run_check("r50",    50,  10, 0);
    run_check("f80",   200,  80, 0);
    run_check("r51f0",  51,   0, 1);

    // packet error during capture
    bms = ms_cnt;
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("perr_err",  int'(err), 1);
    chk("perr_busy", int'(busy), 0);
    chk("perr_led",  int'(update_led), 1);
    chk("perr_nmatch", ms_cnt - bms, 0);

    // done on the last allowed wait cycle is accepted
    step(1, 0, 0, 0, 0, 0, 0);
    idle(16);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("tmo_edge_err",  int'(err), 0);
    chk("tmo_edge_busy", int'(busy), 0);

    // no done for the full budget: error cycle then idle
    step(1, 0, 0, 0, 0, 0, 0);
    idle(17);
    chk("tmo_err",      int'(err), 1);
    chk("tmo_err_busy", int'(busy), 1);
    idle(1);
    chk("tmo_idle", int'(busy), 0);
    chk("tmo_led",  int'(update_led), 1);

    // match engine timeout
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(17);
    chk("mtmo_err", int'(err), 1);
    idle(1);

    // done and err together: done wins
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 1, 0, 0, 0);
    chk("dne_match_start", int'(match_start), 1);
    chk("dne_err", int'(err), 0);
    idle(1);
    step(0, 0, 0, 0, 1, 100, 0);
    chk("dne_ok", int'(match_ok), 1);

    // both requests together, then a check while busy
    bps = ps_cnt;
    step(1, 1, 0, 0, 0, 0, 0);
    chk("both_cmd", int'(pkt_cmd), 1);
    idle(2);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    chk("both_npkt", ps_cnt - bps, 1);
    chk("both_cd",   int'(check_done), 0);

    // reset during match wait
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    #2 rst = 1;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_led",  int'(update_led), 0);
    chk("mrst_ws",   int'(write_sel), 0);
    @(posedge clk); #1 rst = 0;
    step(0, 0, 0, 0, 1, 200, 0);
    chk("mrst_cd",   int'(check_done), 0);
    chk("mrst_busy2", int'(busy), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int mr, mf, sel;
      sel = int'($urandom_range(0, 4));
      mr = (sel == 0) ? 50 : (sel == 1) ? 51 : int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 4));
      mf = (sel == 0) ? 80 : (sel == 1) ? 79 : int'($urandom_range(0, 255));
      step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 12, mr, mf);
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_session_ctrl.md
# fp_session_ctrl

Session controller for the fingerprint path. Turns debounced key pulses into ordered operations: enroll a template, or capture a test print and run the match. It drives the AS608 packet engine's command handshake and the fingerprint-store bank select, then triggers the display/match engine. It judges the returned scores against thresholds and owns the status LEDs. It sits between `key`, the UART packet engine, `fp_store` and `display`, all in the `video_clk` domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 33_000_000 — max wait cycles for any `pkt_done`/`match_done`
- `CNT_W`, 26 — timeout counter width; must hold `TIMEOUT_CYCLES`
- `RIGHT_TH`, 50 — `max_right` must be strictly greater
- `FALSE_TH`, 80 — `max_false` must be strictly less

Ports:
- `clk` in 1 — pixel/system clock
- `rst` in 1 — asynchronous, active-high reset
- `update_req` in 1 — one-cycle enroll request
- `check_req` in 1 — one-cycle check request
- `pkt_start` out 1 — one-cycle command strobe to packet engine
- `pkt_cmd` out 2 — 2'b01 enroll to template bank, 2'b10 capture to test bank, 2'b00 idle
- `pkt_done` in 1 — one-cycle completion from packet engine
- `pkt_err` in 1 — one-cycle failure from packet engine
- `write_sel` out 1 — store bank select: 0 template, 1 test
- `match_start` out 1 — one-cycle strobe to match engine
- `match_done` in 1 — one-cycle, scores valid this cycle
- `max_right` in 8 — best genuine score
- `max_false` in 8 — best impostor score
- `busy` out 1 — session in progress
- `update_led` out 1 — template stored (sticky until `rst`)
- `check_done` out 1 — last check finished
- `match_ok` out 1 — last check passed; valid while `check_done`
- `err` out 1 — last session failed (sticky)

## Operation
- All outputs are registered. Reset values are all 0, `pkt_cmd`=00, and state IDLE.
- **IDLE:**
  - `update_req` goes to ENR_ISSUE.
  - `check_req` with `update_led`=1 goes to CHK_ISSUE.
  - `check_req` with `update_led`=0 sets `err`=1, stays IDLE, and issues no command.
  - Both requests in the same cycle: update wins and check is dropped.
  - Accepting any request clears `err`, `check_done` and `match_ok`.
- **ENR_ISSUE** (1 cycle): `pkt_start`=1, `pkt_cmd`=01, `write_sel`=0, counter←0. Next state ENR_WAIT.
- **ENR_WAIT:**
  - `pkt_done` sets `update_led`=1 and goes to IDLE.
  - `pkt_err` or timeout goes to ERR.
- **CHK_ISSUE** (1 cycle): `pkt_start`=1, `pkt_cmd`=10, `write_sel`=1, counter←0. Next state CHK_WAIT.
- **CHK_WAIT:**
  - `pkt_done` goes to MATCH_ISSUE.
  - `pkt_err` or timeout goes to ERR.
- **MATCH_ISSUE** (1 cycle): `match_start`=1, counter←0, `write_sel` held at 1. Next state MATCH_WAIT.
- **MATCH_WAIT:**
  - `match_done` latches `match_ok` = (`max_right` > `RIGHT_TH`) && (`max_false` < `FALSE_TH`) as unsigned 8-bit compares, sets `check_done`=1 and goes to IDLE.
  - Timeout goes to ERR.
- **ERR** (1 cycle): sets `err`=1, then IDLE. `update_led` is unchanged.
- `write_sel` holds its last value in IDLE. It changes only in the ISSUE states.
- `pkt_cmd` returns to 00 in every state other than ENR_ISSUE and CHK_ISSUE.
- `busy`=1 in every state except IDLE.
- Requests arriving while `busy`=1 are ignored, not queued.
- `pkt_done`, `pkt_err` and `match_done` outside their WAIT state are ignored.

## Timing
- Request sampled at edge k: `pkt_start`/`pkt_cmd`/`write_sel` valid and `busy`=1 during cycle k+1.
- Wait counter:
  - Increments once per WAIT cycle.
  - Timeout fires when it equals `TIMEOUT_CYCLES`-1 with no done that cycle.
  - A done arriving on wait cycle `TIMEOUT_CYCLES` is therefore still accepted.
- Simultaneous done and err, or done and timeout, in the same cycle: done wins.
- `pkt_done` at edge m in CHK_WAIT: `match_start`=1 in cycle m+1.
- `match_done` at edge m: `check_done`/`match_ok` valid and `busy`=0 from cycle m+1.
- Back-to-back sessions: a new request is accepted on the first IDLE cycle.
- `rst` asserted mid-session: immediate return to IDLE with all outputs at reset values, including `update_led`=0. No residual strobes after release.

## Test plan
Scenarios use `TIMEOUT_CYCLES`=16.
- Enroll: `update_req` pulse, `pkt_done` 5 cycles later -> one `pkt_start` with `pkt_cmd`=01, `write_sel`=0; `update_led`=1; `busy` low after done.
- Check pass: after enroll, `check_req`, `pkt_done`, then `match_done` with right=51, false=79 -> `write_sel`=1, one `match_start`, `check_done`=1, `match_ok`=1.
- Threshold edges, three separate checks:
  - right=50, false=10 -> `match_ok`=0.
  - right=200, false=80 -> `match_ok`=0.
  - right=51, false=0 -> `match_ok`=1.
- Errors:
  - `check_req` before any enroll -> `err`=1, no `pkt_start`.
  - `pkt_err` in CHK_WAIT -> `err`=1, no `match_start`, `update_led` stays 1.
- Timeout boundary:
  - Done on wait cycle 16 -> accepted.
  - No done for 16 wait cycles -> ERR.
  - `pkt_done` and `pkt_err` in the same cycle -> treated as done.
- Contention and reset:
  - `update_req` and `check_req` in the same cycle -> enroll only.
  - `check_req` while busy -> ignored.
  - `rst` in MATCH_WAIT -> all outputs 0 immediately; a later `match_done` is ignored.
